// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one command's payload, then streams header,
// payload and XOR parity into router_top, honouring busy and watching err.
module router_pkt_tx #(
  parameter int MAX_LEN      = 63,
  parameter int BUSY_TIMEOUT = 255,
  parameter int ERR_WIN      = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [1:0]  i_addr,
  input  logic [5:0]  i_len,
  output logic        o_cmd_ready,
  output logic        o_cmd_rej,
  input  logic [7:0]  i_pl_data,
  input  logic        i_pl_valid,
  output logic        o_pl_ready,
  input  logic        i_busy,
  input  logic        i_err,
  output logic        o_pkt_valid,
  output logic [7:0]  o_data_in,
  output logic        o_done,
  output logic        o_tx_err,
  output logic        o_abort,
  output logic [15:0] o_pkt_cnt
);

  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int WW = $clog2(ERR_WIN + 1);
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TIMEOUT - 1);
  localparam logic [WW-1:0] WIN_INIT  = WW'(ERR_WIN);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HDR, S_PAY, S_PAR, S_CHK} state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_addr;
  logic [5:0]      r_len;
  logic [5:0]      r_wr_idx, r_rd_idx;
  logic [7:0]      r_par;
  logic [7:0]      r_buf [0:MAX_LEN-1];
  logic [BW-1:0]   r_busy_cnt;
  logic [WW-1:0]   r_win_cnt;
  logic            r_err_flag;
  logic            r_cmd_ready, r_cmd_rej, r_pl_ready, r_pkt_valid;
  logic [7:0]      r_data;
  logic            r_done, r_tx_err, r_abort;
  logic [15:0]     r_pkt_cnt;

  logic w_cmd_ok, w_accept, w_last_wr, w_last_rd, w_send, w_xfer, w_timeout;

  assign w_cmd_ok  = (i_addr != 2'd3) && (i_len != 6'd0) && (32'(i_len) <= MAX_LEN);
  assign w_accept  = (r_state == S_LOAD) && i_pl_valid && r_pl_ready;
  assign w_last_wr = (r_wr_idx == r_len - 6'd1);
  assign w_last_rd = (r_rd_idx == r_len - 6'd1);
  assign w_send    = (r_state == S_HDR) || (r_state == S_PAY) || (r_state == S_PAR);
  assign w_xfer    = w_send && !i_busy;
  // The BUSY_TIMEOUT-th consecutive stalled cycle aborts the packet.
  assign w_timeout = w_send && i_busy && (r_busy_cnt == BUSY_LAST);

  assign o_cmd_ready = r_cmd_ready;
  assign o_cmd_rej   = r_cmd_rej;
  assign o_pl_ready  = r_pl_ready;
  assign o_pkt_valid = r_pkt_valid;
  assign o_data_in   = r_data;
  assign o_done      = r_done;
  assign o_tx_err    = r_tx_err;
  assign o_abort     = r_abort;
  assign o_pkt_cnt   = r_pkt_cnt;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start && w_cmd_ok) w_next = S_LOAD;
      S_LOAD: if (w_accept && w_last_wr) w_next = S_HDR;
      S_HDR:  if (w_timeout) w_next = S_IDLE;
              else if (w_xfer) w_next = S_PAY;
      S_PAY:  if (w_timeout) w_next = S_IDLE;
              else if (w_xfer && w_last_rd) w_next = S_PAR;
      S_PAR:  if (w_timeout) w_next = S_IDLE;
              else if (w_xfer) w_next = S_CHK;
      S_CHK:  if (r_win_cnt == WW'(1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Payload buffer: plain storage, no reset needed.
  always_ff @(posedge clock) begin
    if (w_accept) r_buf[r_wr_idx] <= i_pl_data;
  end

  // Datapath and registered outputs; the next byte is staged on the same
  // edge the current one transfers, so the stream has no bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_par       <= '0;
      r_busy_cnt  <= '0;
      r_win_cnt   <= '0;
      r_err_flag  <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_cmd_rej   <= 1'b0;
      r_pl_ready  <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_tx_err    <= 1'b0;
      r_abort     <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      r_cmd_ready <= (w_next == S_IDLE);
      r_pl_ready  <= (w_next == S_LOAD);
      r_cmd_rej   <= (r_state == S_IDLE) && i_start && !w_cmd_ok;
      r_done      <= 1'b0;
      r_tx_err    <= 1'b0;
      r_abort     <= 1'b0;
      r_busy_cnt  <= (w_send && i_busy) ? r_busy_cnt + 1'b1 : '0;

      if (w_timeout) begin
        r_abort     <= 1'b1;
        r_pkt_valid <= 1'b0;
        r_data      <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (i_start && w_cmd_ok) begin
            r_addr   <= i_addr;
            r_len    <= i_len;
            r_par    <= {i_len, i_addr};
            r_wr_idx <= '0;
          end
          S_LOAD: if (w_accept) begin
            r_par    <= r_par ^ i_pl_data;
            r_wr_idx <= r_wr_idx + 6'd1;
            if (w_last_wr) begin
              r_data      <= {r_len, r_addr};
              r_pkt_valid <= 1'b1;
              r_rd_idx    <= '0;
            end
          end
          S_HDR: if (w_xfer) r_data <= r_buf[0];
          S_PAY: if (w_xfer) begin
            if (w_last_rd) begin
              r_data      <= r_par;
              r_pkt_valid <= 1'b0;
            end else begin
              r_data   <= r_buf[r_rd_idx + 6'd1];
              r_rd_idx <= r_rd_idx + 6'd1;
            end
          end
          S_PAR: if (w_xfer) begin
            r_data     <= '0;
            r_win_cnt  <= WIN_INIT;
            r_err_flag <= 1'b0;
          end
          S_CHK: begin
            r_err_flag <= r_err_flag | i_err;
            r_win_cnt  <= r_win_cnt - 1'b1;
            if (r_win_cnt == WW'(1)) begin
              r_done    <= 1'b1;
              r_tx_err  <= r_err_flag | i_err;
              r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx with a byte scoreboard on the router side.
module tb_router_pkt_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_start;
  logic [1:0]  i_addr;
  logic [5:0]  i_len;
  logic        o_cmd_ready, o_cmd_rej;
  logic [7:0]  i_pl_data;
  logic        i_pl_valid;
  logic        o_pl_ready;
  logic        i_busy, i_err;
  logic        o_pkt_valid;
  logic [7:0]  o_data_in;
  logic        o_done, o_tx_err, o_abort;
  logic [15:0] o_pkt_cnt;

  router_pkt_tx dut (
    .clock(clock), .reset(reset),
    .i_start(i_start), .i_addr(i_addr), .i_len(i_len),
    .o_cmd_ready(o_cmd_ready), .o_cmd_rej(o_cmd_rej),
    .i_pl_data(i_pl_data), .i_pl_valid(i_pl_valid), .o_pl_ready(o_pl_ready),
    .i_busy(i_busy), .i_err(i_err),
    .o_pkt_valid(o_pkt_valid), .o_data_in(o_data_in),
    .o_done(o_done), .o_tx_err(o_tx_err), .o_abort(o_abort),
    .o_pkt_cnt(o_pkt_cnt)
  );

  always #5 clock = ~clock;

  int         nvec = 0;
  int         nerr = 0;
  logic [8:0] sb[$];     // {pkt_valid, byte} expected per transfer
  logic [7:0] pl_q[$];
  logic       mon_en = 1'b0;
  logic       in_pkt = 1'b0;
  logic [8:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Router-side monitor: a byte transfers on each edge with busy low.
  always @(negedge clock) begin
    if (mon_en && !reset && !i_busy && (o_pkt_valid || in_pkt)) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        mon_exp = sb.pop_front();
        chk("tx_byte", {o_pkt_valid, o_data_in}, mon_exp);
      end
      in_pkt = o_pkt_valid;
    end
  end

  task automatic send(input logic [1:0] a, input logic [5:0] l);
    logic [7:0] p;
    int i, g;
    logic rdy;
    p = {l, a};
    sb.push_back({1'b1, p});
    for (int k = 0; k < int'(l); k++) begin
      sb.push_back({1'b1, pl_q[k]});
      p = p ^ pl_q[k];
    end
    sb.push_back({1'b0, p});
    i_addr = a; i_len = l; i_start = 1'b1;
    @(posedge clock); #1 i_start = 1'b0;
    @(negedge clock);
    chk("load_cmd_ready", o_cmd_ready, 0);
    chk("load_pl_ready", o_pl_ready, 1);
    i = 0; g = 0;
    while (i < int'(l) && g < 500) begin
      i_pl_valid = 1'b1; i_pl_data = pl_q[i];
      rdy = o_pl_ready;
      @(posedge clock);
      if (rdy) i++;
      g++;
      @(negedge clock);
    end
    i_pl_valid = 1'b0;
    chk("load_count", i, int'(l));
  endtask

  task automatic wait_byte(input logic v, input logic [7:0] d, input string tag);
    int g = 0;
    while (!(o_pkt_valid === v && o_data_in === d) && g < 2000) begin
      @(negedge clock); g++;
    end
    chk(tag, {o_pkt_valid, o_data_in}, {v, d});
  endtask

  task automatic wait_done(input logic e, input logic [15:0] cnt);
    int g = 0;
    while (o_done !== 1'b1 && g < 500) begin
      @(negedge clock); g++;
    end
    chk("done_seen", o_done, 1);
    chk("tx_err", o_tx_err, e);
    chk("pkt_cnt", o_pkt_cnt, cnt);
    chk("sb_drained", sb.size(), 0);
    @(negedge clock);
    chk("done_pulse", o_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; i_start = 1'b0; i_addr = '0; i_len = '0;
    i_pl_data = '0; i_pl_valid = 1'b0; i_busy = 1'b0; i_err = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_pkt_valid", o_pkt_valid, 0);
    chk("rst_data_in", o_data_in, 0);
    chk("rst_pl_ready", o_pl_ready, 0);
    chk("rst_pkt_cnt", o_pkt_cnt, 0);
    chk("rst_flags", {o_done, o_tx_err, o_abort, o_cmd_rej}, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // 1: addr=1, len=16, payload 1..16, no stalls
    pl_q.delete();
    for (int k = 1; k <= 16; k++) pl_q.push_back(8'(k));
    send(2'd1, 6'd16);
    chk("t1_header", {o_pkt_valid, o_data_in}, {1'b1, 8'h41});
    n = 0;
    while (o_pkt_valid && n < 100) begin n++; @(negedge clock); end
    chk("t1_valid_cycles", n, 17);
    chk("t1_parity", {o_pkt_valid, o_data_in}, {1'b0, 8'h51});
    wait_done(1'b0, 16'd1);

    // 2: same packet, busy for 3 cycles while byte 5 is presented
    send(2'd1, 6'd16);
    wait_byte(1'b1, 8'h04, "t2_byte4");
    @(posedge clock); #1 i_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t2_hold", {o_pkt_valid, o_data_in}, {1'b1, 8'h05});
      @(posedge clock);
    end
    #1 i_busy = 1'b0;
    wait_byte(1'b0, 8'h51, "t2_parity");
    wait_done(1'b0, 16'd2);

    // 3: invalid commands are rejected in IDLE
    i_addr = 2'd3; i_len = 6'd4; i_start = 1'b1;
    @(posedge clock); #1 i_start = 1'b0;
    @(negedge clock);
    chk("t3_rej_addr", o_cmd_rej, 1);
    chk("t3_cmd_ready", o_cmd_ready, 1);
    chk("t3_pl_ready", o_pl_ready, 0);
    @(negedge clock);
    chk("t3_rej_pulse", o_cmd_rej, 0);
    chk("t3_pl_ready2", o_pl_ready, 0);
    i_addr = 2'd0; i_len = 6'd0; i_start = 1'b1;
    @(posedge clock); #1 i_start = 1'b0;
    @(negedge clock);
    chk("t3_rej_len", o_cmd_rej, 1);
    chk("t3_cmd_ready_b", o_cmd_ready, 1);

    // 4: addr=2, len=1, payload A5, err one cycle after parity
    pl_q.delete(); pl_q.push_back(8'hA5);
    send(2'd2, 6'd1);
    chk("t4_header", {o_pkt_valid, o_data_in}, {1'b1, 8'h06});
    wait_byte(1'b0, 8'hA3, "t4_parity");
    @(posedge clock); #1 i_err = 1'b1;
    @(posedge clock); #1 i_err = 1'b0;
    wait_done(1'b1, 16'd3);

    // 5: busy timeout in PAY
    pl_q.delete();
    pl_q.push_back(8'h11); pl_q.push_back(8'h22);
    pl_q.push_back(8'h33); pl_q.push_back(8'h44);
    send(2'd0, 6'd4);
    wait_byte(1'b1, 8'h22, "t5_byte2");
    @(posedge clock); #1 i_busy = 1'b1; mon_en = 1'b0;
    repeat (254) @(posedge clock);
    @(negedge clock);
    chk("t5_no_early_abort", o_abort, 0);
    chk("t5_still_valid", {o_pkt_valid, o_data_in}, {1'b1, 8'h33});
    @(posedge clock);
    @(negedge clock);
    chk("t5_abort", o_abort, 1);
    chk("t5_pkt_valid", o_pkt_valid, 0);
    chk("t5_data_in", o_data_in, 0);
    chk("t5_pkt_cnt", o_pkt_cnt, 3);
    @(posedge clock); #1 i_busy = 1'b0;
    @(negedge clock);
    chk("t5_abort_pulse", o_abort, 0);
    chk("t5_cmd_ready", o_cmd_ready, 1);
    sb.delete(); in_pkt = 1'b0; mon_en = 1'b1;

    // 6: reset on the 3rd payload byte, then a fresh len=2 packet
    pl_q.delete();
    pl_q.push_back(8'h55); pl_q.push_back(8'h66);
    pl_q.push_back(8'h77); pl_q.push_back(8'h88);
    send(2'd2, 6'd4);
    wait_byte(1'b1, 8'h77, "t6_byte3");
    mon_en = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("t6_pkt_valid", o_pkt_valid, 0);
    chk("t6_cmd_ready", o_cmd_ready, 1);
    chk("t6_pkt_cnt", o_pkt_cnt, 0);
    chk("t6_data_in", o_data_in, 0);
    reset = 1'b0;
    sb.delete(); in_pkt = 1'b0; mon_en = 1'b1;
    pl_q.delete(); pl_q.push_back(8'h3C); pl_q.push_back(8'hC3);
    send(2'd0, 6'd2);
    chk("t6_header", {o_pkt_valid, o_data_in}, {1'b1, 8'h08});
    wait_byte(1'b0, 8'hF7, "t6_parity");
    wait_done(1'b0, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
